// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: words, FSM encodings, exception codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_fetch_unit_pkg;

    localparam int WORD_W = 32;

    // Bubble instruction and all-zero word used on invalid or flushed IF/ID.
    localparam logic [WORD_W-1:0] NOP_WORD  = '0;
    localparam logic [WORD_W-1:0] ZERO_WORD = '0;

    // Cause code reported downstream for a misaligned fetch address.
    localparam logic [3:0] EXC_FETCH_MISALIGNED = 4'd0;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_BUFFER = 2'd3
    } fetch_state_t;

    // Instruction words must sit on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory req/ack port between the fetch unit and the memory.
// Latency: ack may arrive in the same cycle as req or any number of cycles later.
// Backpressure: memory stalls the fetch by withholding ack; addr is held until ack.
interface if_fetch_unit_if
    import if_fetch_unit_pkg::*;
#(
    parameter int DATA_W = WORD_W
);
    logic              mem_req_o;
    logic [DATA_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport master (output mem_req_o, mem_addr_o, input mem_ack_i, mem_rdata_i);
    modport slave  (input mem_req_o, mem_addr_o, output mem_ack_i, mem_rdata_i);
endinterface

// File: rtl/if_fetch_unit_skid_buf.sv
// One-entry {pc, inst, exc} holding register for a fetch that lands during a stall.
// Latency: loaded entry is visible on the cycle after load.
// Backpressure: none internally; owner must not load while full unless clearing.
module if_fetch_unit_skid_buf
    import if_fetch_unit_pkg::*;
#(
    parameter int DATA_W = WORD_W
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load,
    input  logic              drain,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_inst,
    input  logic              in_exc,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst,
    output logic              out_exc,
    output logic              full
);

    // Clear wins over load so a flush never leaves a stale entry behind.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            full     <= 1'b0;
            out_pc   <= '0;
            out_inst <= '0;
            out_exc  <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full     <= 1'b1;
            out_pc   <= in_pc;
            out_inst <= in_inst;
            out_exc  <= in_exc;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: reads the word at pc_i and owns the IF/ID pipeline register.
// Latency: 0-wait memory loads IF/ID on the edge ending the request; N waits add N bubbles.
// Backpressure: stall_i holds IF/ID (one extra fetch parks in the skid buffer); stall_req_o holds PC.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                DATA_W   = WORD_W,
    parameter logic [DATA_W-1:0] NOP_INST = NOP_WORD
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              stall_i,
    input  logic              flush_i,
    if_fetch_unit_if.master   mem,
    output logic              stall_req_o,
    output logic [DATA_W-1:0] if_pc_o,
    output logic [DATA_W-1:0] if_inst_o,
    output logic              if_valid_o,
    output logic              if_exc_o
);

    fetch_state_t      state;
    logic [DATA_W-1:0] addr_q;

    logic              req_c;
    logic [DATA_W-1:0] addr_c;
    logic              capture;
    logic [DATA_W-1:0] cap_pc;
    logic [DATA_W-1:0] cap_inst;
    logic              cap_exc;

    logic [DATA_W-1:0] skid_pc;
    logic [DATA_W-1:0] skid_inst;
    logic              skid_exc;
    logic              skid_full;
    logic              skid_load;
    logic              skid_drain;

    // Request/capture decode; a capture is what lets PC advance this cycle.
    always_comb begin
        req_c    = 1'b0;
        addr_c   = addr_q;
        capture  = 1'b0;
        cap_pc   = pc_i;
        cap_inst = mem.mem_rdata_i;
        cap_exc  = 1'b0;
        case (state)
            ST_FETCH: begin
                addr_c = pc_i;
                if (is_misaligned(pc_i[1:0])) begin
                    // Misaligned: no memory access, retire a NOP flagged as an exception.
                    capture  = 1'b1;
                    cap_inst = NOP_INST;
                    cap_exc  = 1'b1;
                end else begin
                    req_c   = 1'b1;
                    capture = mem.mem_ack_i;
                end
            end
            ST_WAIT: begin
                req_c   = 1'b1;
                cap_pc  = addr_q;
                capture = mem.mem_ack_i;
            end
            ST_DRAIN: begin
                req_c = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Reset aborts any outstanding request immediately and holds PC.
    assign mem.mem_req_o  = rst_i & req_c;
    assign mem.mem_addr_o = rst_i ? addr_c : '0;
    assign stall_req_o    = ~rst_i | ~capture;

    assign skid_load  = capture & stall_i & ~flush_i;
    assign skid_drain = (state == ST_BUFFER) & skid_full & ~stall_i & ~flush_i;

    if_fetch_unit_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (skid_load),
        .drain    (skid_drain),
        .clear    (flush_i),
        .in_pc    (cap_pc),
        .in_inst  (cap_inst),
        .in_exc   (cap_exc),
        .out_pc   (skid_pc),
        .out_inst (skid_inst),
        .out_exc  (skid_exc),
        .full     (skid_full)
    );

    // FSM, held request address and IF/ID register; flush outranks stall and ack.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= ST_FETCH;
            addr_q     <= '0;
            if_pc_o    <= '0;
            if_inst_o  <= NOP_INST;
            if_valid_o <= 1'b0;
            if_exc_o   <= 1'b0;
        end else if (flush_i) begin
            if_pc_o    <= '0;
            if_inst_o  <= NOP_INST;
            if_valid_o <= 1'b0;
            if_exc_o   <= 1'b0;
            // An unanswered request must still complete; its data is thrown away.
            if (req_c && !mem.mem_ack_i) begin
                state  <= ST_DRAIN;
                addr_q <= addr_c;
            end else begin
                state <= ST_FETCH;
            end
        end else if (capture) begin
            state <= stall_i ? ST_BUFFER : ST_FETCH;
            if (!stall_i) begin
                if_pc_o    <= cap_pc;
                if_inst_o  <= cap_inst;
                if_valid_o <= 1'b1;
                if_exc_o   <= cap_exc;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    addr_q <= pc_i;
                    state  <= ST_WAIT;
                    if (!stall_i) begin
                        if_inst_o  <= NOP_INST;
                        if_valid_o <= 1'b0;
                        if_exc_o   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (!stall_i) begin
                        if_inst_o  <= NOP_INST;
                        if_valid_o <= 1'b0;
                        if_exc_o   <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if_inst_o  <= NOP_INST;
                    if_valid_o <= 1'b0;
                    if_exc_o   <= 1'b0;
                    if (mem.mem_ack_i) begin
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    if (!stall_i) begin
                        if_pc_o    <= skid_pc;
                        if_inst_o  <= skid_inst;
                        if_valid_o <= skid_full;
                        if_exc_o   <= skid_exc;
                        state      <= ST_FETCH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: memory model with programmable wait states,
// a PC stage that advances on !stall_req_o, a scoreboard of fetched words, and vectors.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i;
    logic        stall_i;
    logic        flush_i;
    logic        stall_req_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
    logic        if_exc_o;

    int          checks = 0;
    int          errors = 0;
    int          waits_cfg = 0;
    int          wait_cnt;
    logic [31:0] flush_target = 32'h0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [31:0] pc;
        int          waits;
        int          exp_stalls;
        logic        exp_req;
        logic        exp_exc;
        logic [31:0] exp_inst;
    } vec_t;
    vec_t vecs[7];

    if_fetch_unit_if #(.DATA_W(32)) mif ();

    if_fetch_unit dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .pc_i        (pc_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .mem         (mif),
        .stall_req_o (stall_req_o),
        .if_pc_o     (if_pc_o),
        .if_inst_o   (if_inst_o),
        .if_valid_o  (if_valid_o),
        .if_exc_o    (if_exc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Memory: acks once the request has been pending waits_cfg cycles.
    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) wait_cnt <= 0;
        else if (mif.mem_req_o && !mif.mem_ack_i) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end
    assign mif.mem_ack_i   = mif.mem_req_o && (wait_cnt >= waits_cfg);
    assign mif.mem_rdata_i = memf(mif.mem_addr_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: scoreboard and address-stability checks mid-cycle, then PC update.
    task automatic cycle();
        logic adv;
        logic do_flush;
        sb_t  e;
        @(negedge clk);
        if (!rst_i) begin
            sbq.delete();
        end else begin
            if (prev_pend) chk("addr_stable", mif.mem_addr_o, prev_addr);
            if (if_valid_o && !stall_i && !flush_i) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_dup: IF/ID pc %h with nothing outstanding", if_pc_o);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_pc", if_pc_o, e.pc);
                    chk("sb_inst", if_inst_o, e.inst);
                    chk("sb_exc", if_exc_o, e.exc);
                end
            end
            if (!stall_req_o && !flush_i) begin
                e.pc   = pc_i;
                e.exc  = (pc_i[1:0] != 2'b00);
                e.inst = e.exc ? NOP : memf(pc_i);
                sbq.push_back(e);
            end
            if (flush_i) sbq.delete();
        end
        prev_pend = rst_i && mif.mem_req_o && !mif.mem_ack_i;
        prev_addr = mif.mem_addr_o;
        adv      = rst_i && !stall_req_o;
        do_flush = rst_i && flush_i;
        @(posedge clk);
        #1;
        if (do_flush) pc_i = flush_target;
        else if (adv) pc_i = pc_i + 32'd4;
        #1;
    endtask

    task automatic reset_dut();
        rst_i     = 1'b0;
        stall_i   = 1'b0;
        flush_i   = 1'b0;
        pc_i      = 32'h0;
        waits_cfg = 0;
        prev_pend = 1'b0;
        sbq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b1;
        #1;
    endtask

    initial begin
        int n;
        rst_i   = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        pc_i    = 32'h0;

        vecs[0] = '{32'h000, 0, 0, 1'b1, 1'b0, memf(32'h000)};
        vecs[1] = '{32'h010, 2, 2, 1'b1, 1'b0, memf(32'h010)};
        vecs[2] = '{32'h024, 1, 1, 1'b1, 1'b0, memf(32'h024)};
        vecs[3] = '{32'h006, 0, 0, 1'b0, 1'b1, NOP};
        vecs[4] = '{32'h041, 3, 0, 1'b0, 1'b1, NOP};
        vecs[5] = '{32'h0FC, 4, 4, 1'b1, 1'b0, memf(32'h0FC)};
        vecs[6] = '{32'h003, 1, 0, 1'b0, 1'b1, NOP};

        // Reset state.
        #3;
        chk("rst_pc", if_pc_o, 32'h0);
        chk("rst_inst", if_inst_o, NOP);
        chk("rst_valid", if_valid_o, 1'b0);
        chk("rst_exc", if_exc_o, 1'b0);
        chk("rst_req", mif.mem_req_o, 1'b0);
        chk("rst_addr", mif.mem_addr_o, 32'h0);
        chk("rst_stallreq", stall_req_o, 1'b1);

        // Single-fetch vectors: wait states, misalignment, capture contents.
        foreach (vecs[k]) begin
            reset_dut();
            pc_i      = vecs[k].pc;
            waits_cfg = vecs[k].waits;
            #1;
            chk("vec_req", mif.mem_req_o, vecs[k].exp_req);
            n = 0;
            while (stall_req_o && n < 12) begin
                n++;
                cycle();
            end
            chk("vec_stalls", n, vecs[k].exp_stalls);
            cycle();
            chk("vec_pc", if_pc_o, vecs[k].pc);
            chk("vec_inst", if_inst_o, vecs[k].exp_inst);
            chk("vec_exc", if_exc_o, vecs[k].exp_exc);
            chk("vec_valid", if_valid_o, 1'b1);
        end

        // Back-to-back 0-wait fetch.
        reset_dut();
        chk("t1_stallreq", stall_req_o, 1'b0);
        chk("t1_addr", mif.mem_addr_o, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t1_pc", if_pc_o, 32'(i * 4));
            chk("t1_inst", if_inst_o, memf(32'(i * 4)));
            chk("t1_valid", if_valid_o, 1'b1);
            chk("t1_stallreq", stall_req_o, 1'b0);
        end

        // Two wait states at 0x10.
        reset_dut();
        pc_i      = 32'h10;
        waits_cfg = 2;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t2_addr", mif.mem_addr_o, 32'h10);
            chk("t2_stallreq", stall_req_o, (i < 2) ? 1'b1 : 1'b0);
            cycle();
            chk("t2_valid", if_valid_o, (i < 2) ? 1'b0 : 1'b1);
        end
        chk("t2_pc", if_pc_o, 32'h10);
        chk("t2_inst", if_inst_o, memf(32'h10));

        // Downstream stall while the fetch of 0x8 completes.
        reset_dut();
        cycle();
        cycle();
        chk("t3_pc_before", if_pc_o, 32'h4);
        stall_i = 1'b1;
        #1;
        chk("t3_stallreq_cap", stall_req_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t3_hold_pc", if_pc_o, 32'h4);
            chk("t3_no_req", mif.mem_req_o, 1'b0);
            chk("t3_stallreq", stall_req_o, 1'b1);
        end
        stall_i = 1'b0;
        cycle();
        chk("t3_pc_buf", if_pc_o, 32'h8);
        chk("t3_inst_buf", if_inst_o, memf(32'h8));
        chk("t3_pc_i", pc_i, 32'hC);
        cycle();
        chk("t3_pc_next", if_pc_o, 32'hC);

        // Flush during WAIT at 0x20, redirect to 0x100.
        reset_dut();
        pc_i      = 32'h20;
        waits_cfg = 3;
        #1;
        cycle();
        chk("t4_wait_stallreq", stall_req_o, 1'b1);
        flush_i      = 1'b1;
        flush_target = 32'h100;
        cycle();
        flush_i = 1'b0;
        #1;
        chk("t4_drain_addr", mif.mem_addr_o, 32'h20);
        chk("t4_drain_req", mif.mem_req_o, 1'b1);
        chk("t4_drain_stallreq", stall_req_o, 1'b1);
        chk("t4_drain_valid", if_valid_o, 1'b0);
        cycle();
        chk("t4_drain_ack_addr", mif.mem_addr_o, 32'h20);
        chk("t4_drain_ack_stallreq", stall_req_o, 1'b1);
        cycle();
        chk("t4_fetch_addr", mif.mem_addr_o, 32'h100);
        chk("t4_discard_valid", if_valid_o, 1'b0);
        for (int i = 0; i < 10 && !if_valid_o; i++) cycle();
        chk("t4_valid", if_valid_o, 1'b1);
        chk("t4_pc", if_pc_o, 32'h100);
        chk("t4_inst", if_inst_o, memf(32'h100));

        // Reset asserted mid-WAIT while IF/ID holds a valid word.
        reset_dut();
        pc_i = 32'h40;
        #1;
        cycle();
        waits_cfg = 3;
        stall_i   = 1'b1;
        #1;
        cycle();
        chk("t6_pre_valid", if_valid_o, 1'b1);
        chk("t6_pre_req", mif.mem_req_o, 1'b1);
        rst_i = 1'b0;
        #1;
        chk("t6_req", mif.mem_req_o, 1'b0);
        chk("t6_addr", mif.mem_addr_o, 32'h0);
        chk("t6_stallreq", stall_req_o, 1'b1);
        chk("t6_valid", if_valid_o, 1'b0);
        chk("t6_pc", if_pc_o, 32'h0);
        chk("t6_inst", if_inst_o, NOP);
        pc_i    = 32'h0;
        stall_i = 1'b0;
        cycle();
        rst_i     = 1'b1;
        waits_cfg = 0;
        #1;
        chk("t6_restart_req", mif.mem_req_o, 1'b1);
        chk("t6_restart_addr", mif.mem_addr_o, 32'h0);
        cycle();
        chk("t6_restart_pc", if_pc_o, 32'h0);
        chk("t6_restart_inst", if_inst_o, memf(32'h0));
        chk("t6_restart_valid", if_valid_o, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
